// File: rtl/rf_wport_arbiter.sv
// Arbitrates the single register-file write port between WB and a buffered MCU result stream.
// WB has priority; a starvation counter forces one MCU drain by stalling WB.
module rf_wport_arbiter #(
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             wb_we,
  input  logic [4:0]       wb_waddr,
  input  logic [31:0]      wb_wdata,
  output logic             wb_stall,
  input  logic             mcu_valid,
  output logic             mcu_ready,
  input  logic [4:0]       mcu_waddr,
  input  logic [31:0]      mcu_wdata,
  input  logic             flush,
  output logic             rf_we,
  output logic [4:0]       rf_waddr,
  output logic [31:0]      rf_wdata,
  output logic             rf_src,
  output logic [31:0]      pend_mask,
  output logic [CNT_W-1:0] fifo_count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned SW    = $clog2(STARVE_MAX + 1);

  typedef enum logic [0:0] {StNormal, StForce} state_e;

  state_e           state_q, state_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [SW-1:0]    starve_q, starve_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [4:0]       addr_mem [DEPTH];
  logic [31:0]      data_mem [DEPTH];

  logic wb_wr;
  logic empty;
  logic full;
  logic push;
  logic pop;

  // A WB write to r0 is architecturally a no-op and never occupies the port.
  assign wb_wr      = wb_we && (wb_waddr != 5'd0);
  assign empty      = (count_q == '0);
  assign full       = (count_q == CNT_W'(DEPTH));
  assign mcu_ready  = !full;
  assign push       = mcu_valid && mcu_ready && !flush && (mcu_waddr != 5'd0);
  assign fifo_count = count_q;

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    pop      = 1'b0;
    wb_stall = 1'b0;
    rf_src   = 1'b0;
    rf_we    = wb_wr;
    rf_waddr = wb_waddr;
    rf_wdata = wb_wdata;
    unique case (state_q)
      StNormal: begin
        if (wb_wr) begin
          if (flush || empty) begin
            starve_d = '0;
          end else if (starve_q == SW'(STARVE_MAX - 1)) begin
            state_d  = StForce;
            starve_d = '0;
          end else begin
            starve_d = starve_q + SW'(1);
          end
        end else begin
          starve_d = '0;
          if (!empty && !flush) begin
            pop      = 1'b1;
            rf_we    = 1'b1;
            rf_src   = 1'b1;
            rf_waddr = addr_mem[rd_ptr_q];
            rf_wdata = data_mem[rd_ptr_q];
          end
        end
      end
      StForce: begin
        state_d  = StNormal;
        starve_d = '0;
        // A flush cancels the forced drain and lets WB through untouched.
        if (!flush && !empty) begin
          wb_stall = 1'b1;
          pop      = 1'b1;
          rf_we    = 1'b1;
          rf_src   = 1'b1;
          rf_waddr = addr_mem[rd_ptr_q];
          rf_wdata = data_mem[rd_ptr_q];
        end
      end
      default: state_d = StNormal;
    endcase
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    valid_d  = valid_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      valid_d  = '0;
    end else begin
      if (pop) begin
        valid_d[rd_ptr_q] = 1'b0;
        rd_ptr_d          = rd_ptr_q + PTR_W'(1);
      end
      if (push) begin
        valid_d[wr_ptr_q] = 1'b1;
        wr_ptr_d          = wr_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i]) begin
        pend_mask[addr_mem[i]] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= StNormal;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      starve_q <= '0;
      valid_q  <= '0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      valid_q  <= valid_d;
    end
  end

  // Payload storage needs no reset; valid_q qualifies every read.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr_q] <= mcu_waddr;
      data_mem[wr_ptr_q] <= mcu_wdata;
    end
  end

endmodule
